shared_mem_arb: RTL and testbench

Two-requester arbiter that shares the single-port HSEM shared-memory SRAM (512 x 32, `sirv_sim_ram`, 1-cycle read latency) between two bus-side requesters, e.g. two `ahb_sram_biu` instances on separate AHB layers. It sits between those interfaces and the SRAM macro. It grants at most one access per cycle using round-robin priority, and supports a locked sequence in which one requester owns the memory exclusively for read-modify-write semaphore operations. A timeout watchdog force-releases a lock that its owner abandons.

---
 rtl/shared_mem_arb.sv | 159 +++++++++++++++
 tb/tb_shared_mem_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arb.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters,
// with a locked RMW sequence and an idle-timeout watchdog on the lock.
module shared_mem_arb #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_TMO = 255
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          m0_valid,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_ready,
    output logic          m0_rsp_valid,
    output logic [DW-1:0] m0_rsp_rdata,
    input  logic          m1_valid,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_ready,
    output logic          m1_rsp_valid,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          lock_abort
);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(LOCK_TMO - 1);

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic [7:0] tmo_cnt, tmo_nxt;
    logic       last;
    logic [1:0] rsp_pend;
    logic       rsp_rd;

    logic locked;
    logic owner_req;
    logic expire;
    logic hold;
    logic gnt0, gnt1, gnt;
    logic g_write, g_lock;

    // An idle owner on its last allowed cycle loses the lock right now,
    // so the other master can be granted in the same cycle.
    assign locked    = (state == LOCKED);
    assign owner_req = owner ? m1_valid : m0_valid;
    assign expire    = locked & ~owner_req & (tmo_cnt == TMO_LAST);
    assign hold      = locked & ~expire;

    // Grant selection: owner only while held, else round-robin on last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (hresetn) begin
            if (hold) begin
                gnt0 = ~owner & m0_valid;
                gnt1 = owner & m1_valid;
            end else if (m0_valid & m1_valid) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = m0_valid;
                gnt1 = m1_valid;
            end
        end
    end

    assign gnt      = gnt0 | gnt1;
    assign g_write  = gnt1 ? m1_write : m0_write;
    assign g_lock   = gnt1 ? m1_lock : m0_lock;
    assign m0_ready = gnt0;
    assign m1_ready = gnt1;

    assign sram_cs    = gnt;
    assign sram_we    = gnt & g_write;
    assign sram_addr  = gnt1 ? m1_addr : (gnt0 ? m0_addr : '0);
    assign sram_wdata = gnt1 ? m1_wdata : (gnt0 ? m0_wdata : '0);

    // Lock next-state, owner, watchdog count and abort pulse.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        tmo_nxt    = tmo_cnt;
        lock_abort = 1'b0;
        unique case (state)
            UNLOCKED: begin
                tmo_nxt = 8'd0;
                if (gnt & g_lock) begin
                    state_nxt = LOCKED;
                    owner_nxt = gnt1;
                end
            end
            LOCKED: begin
                if (expire) begin
                    lock_abort = 1'b1;
                    tmo_nxt    = 8'd0;
                    if (gnt & g_lock) begin
                        owner_nxt = gnt1;
                    end else begin
                        state_nxt = UNLOCKED;
                    end
                end else if (gnt) begin
                    tmo_nxt = 8'd0;
                    if (!g_lock) begin
                        state_nxt = UNLOCKED;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= UNLOCKED;
            owner   <= 1'b0;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Round-robin history and one-cycle-delayed response tracking.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            last     <= 1'b1;
            rsp_pend <= 2'b00;
            rsp_rd   <= 1'b0;
        end else begin
            if (gnt) begin
                last <= gnt1;
            end
            rsp_pend <= {gnt1, gnt0};
            rsp_rd   <= ~g_write;
        end
    end

    assign m0_rsp_valid = rsp_pend[0];
    assign m1_rsp_valid = rsp_pend[1];
    assign m0_rsp_rdata = (rsp_pend[0] & rsp_rd) ? sram_rdata : '0;
    assign m1_rsp_rdata = (rsp_pend[1] & rsp_rd) ? sram_rdata : '0;

endmodule

// File: tb/tb_shared_mem_arb.sv
// Bench for shared_mem_arb: vector table with a response scoreboard,
// a behavioural 1-cycle SRAM, and a hand-driven reset-mid-lock sequence.
module tb_shared_mem_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          hclk;
    logic          hresetn;
    logic          m0_valid, m0_write, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ready, m0_rsp_valid;
    logic [DW-1:0] m0_rsp_rdata;
    logic          m1_valid, m1_write, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ready, m1_rsp_valid;
    logic [DW-1:0] m1_rsp_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          lock_abort;

    shared_mem_arb #(.AW(AW), .DW(DW), .LOCK_TMO(TMO)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_ready(m0_ready),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_ready(m1_ready),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .lock_abort(lock_abort)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [31:0] pat(input int a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0203);
    endfunction

    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];

    // Behavioural SRAM with one-cycle read latency.
    initial begin
        sram_rdata = '0;
        for (int i = 0; i < 512; i++) mem[i] = pat(i);
        forever begin
            @(posedge hclk);
            if (sram_cs) begin
                if (sram_we) mem[sram_addr[8:0]] = sram_wdata;
                else sram_rdata <= mem[sram_addr[8:0]];
            end
        end
    end

    typedef struct {
        logic        v0, w0, l0;
        logic [31:0] a0, d0;
        logic        v1, w1, l1;
        logic [31:0] a1, d1;
        logic        er0, er1, eab;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    rsp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input logic v0, input logic w0, input logic [31:0] a0,
        input logic [31:0] d0, input logic l0,
        input logic v1, input logic w1, input logic [31:0] a1,
        input logic [31:0] d1, input logic l1,
        input logic er0, input logic er1, input logic eab);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.er0 = er0; v.er1 = er1; v.eab = eab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, check, then score the grant.
    task automatic step(input vec_t v);
        logic [31:0] ea, ed, e0, e1;
        logic        ewe;
        logic [1:0]  ev;
        rsp_t        r;
        m0_valid = v.v0; m0_write = v.w0; m0_addr = v.a0;
        m0_wdata = v.d0; m0_lock = v.l0;
        m1_valid = v.v1; m1_write = v.w1; m1_addr = v.a1;
        m1_wdata = v.d1; m1_lock = v.l1;
        #1;
        ea  = v.er0 ? v.a0 : (v.er1 ? v.a1 : 32'd0);
        ed  = v.er0 ? v.d0 : (v.er1 ? v.d1 : 32'd0);
        ewe = v.er0 ? v.w0 : (v.er1 ? v.w1 : 1'b0);
        chk("ready", 32'({m1_ready, m0_ready}), 32'({v.er1, v.er0}));
        chk("sram_cs_we", 32'({sram_cs, sram_we}),
            32'({v.er0 | v.er1, ewe}));
        chk("sram_addr", sram_addr, ea);
        chk("sram_wdata", sram_wdata, ed);
        chk("lock_abort", 32'(lock_abort), 32'(v.eab));
        ev = 2'b00;
        e0 = 32'd0;
        e1 = 32'd0;
        if (sbq.size() > 0) begin
            r = sbq.pop_front();
            if (r.port) begin
                ev = 2'b10;
                e1 = r.data;
            end else begin
                ev = 2'b01;
                e0 = r.data;
            end
        end
        chk("rsp_valid", 32'({m1_rsp_valid, m0_rsp_valid}), 32'(ev));
        if (ev[0]) chk("m0_rsp_rdata", m0_rsp_rdata, e0);
        if (ev[1]) chk("m1_rsp_rdata", m1_rsp_rdata, e1);
        if (v.er0 | v.er1) begin
            r.port = v.er1;
            if (ewe) begin
                ref_mem[ea[8:0]] = ed;
                r.data = 32'd0;
            end else begin
                r.data = ref_mem[ea[8:0]];
            end
            sbq.push_back(r);
        end
        @(negedge hclk);
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // contention after reset: m0, m1, m0, m1
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0));
        tbl.push_back(idle);
        // solo write then read back
        tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(idle);
        // locked RMW by m1 with m0 write pending
        tbl.push_back(mk(1, 1, 7, 32'h12345678, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 32'h12345678, 0, 1, 1, 0, 32'hCAFE0001, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(idle);
        // lock timeout: abort and m1 grant 4 cycles after m0 grant
        tbl.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1, 1));
        tbl.push_back(idle);
        // owner re-request on the expiry cycle keeps the lock
        tbl.push_back(mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 9, 0, 1, 1, 0, 10, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 1, 1));
        tbl.push_back(idle);

        // reset state with both requesters asking
        hresetn  = 1'b0;
        m0_valid = 1'b1; m0_write = 1'b0; m0_addr = '0;
        m0_wdata = '0;   m0_lock = 1'b0;
        m1_valid = 1'b1; m1_write = 1'b0; m1_addr = '0;
        m1_wdata = '0;   m1_lock = 1'b0;
        #12;
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        chk("rst_sram", 32'({sram_cs, sram_we}), 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_rsp_valid", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
        chk("rst_rsp_rdata0", m0_rsp_rdata, 32'd0);
        chk("rst_rsp_rdata1", m1_rsp_rdata, 32'd0);
        chk("rst_abort", 32'(lock_abort), 32'd0);
        @(negedge hclk);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        hresetn  = 1'b1;
        @(negedge hclk);

        foreach (tbl[i]) step(tbl[i]);

        // reset while a locked read is outstanding
        m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'd11; m0_lock = 1'b1;
        m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'd12; m1_lock = 1'b0;
        #1;
        chk("mid_lock_ready", 32'({m1_ready, m0_ready}), 32'b01);
        @(posedge hclk);
        #1 hresetn = 1'b0;
        #1;
        chk("mid_rst_rsp", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
        chk("mid_rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        chk("mid_rst_cs", 32'(sram_cs), 32'd0);
        @(negedge hclk);
        chk("mid_rst_rsp2", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        step(mk(1, 0, 11, 0, 0, 1, 0, 12, 0, 0, 1, 0, 0));
        step(mk(1, 0, 11, 0, 0, 1, 0, 12, 0, 0, 0, 1, 0));
        step(idle);
        step(idle);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
